bwt_scan_ctrl: RTL

- Sequences the exact-match scan of the target (query) buffer against the reference buffer.
- For each reference start position it generates target and reference read addresses, and consumes the 1-bit base-compare result from the external comparator.
- It counts consecutive matches, reports a hit when all TAGT_NUM bases agree, and then advances to the next window.
- It sits between the target/reference memories with their comparator and the downstream hit collector.

---
 rtl/bwt_pkg.sv | 17 +
 rtl/bwt_scan_ctrl_if.sv | 15 +
 rtl/bwt_addr_gen.sv | 81 ++++++++
 rtl/bwt_scan_ctrl.sv | 131 +++++++++++++
 4 files changed

// File: rtl/bwt_pkg.sv
// Shared constants and FSM state encoding for the exact-match scan controller.
package bwt_pkg;

  localparam int TAGT_NUM    = 64;
  localparam int TAGT_LENGTH = 6;
  localparam int REF_NUM     = 1024;
  localparam int REF_LENGTH  = 10;
  localparam int LAST_START  = REF_NUM - TAGT_NUM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2,
    FIN  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/bwt_scan_ctrl_if.sv
// Read-address / compare-result bus between the scan controller and the memories plus comparator.
interface bwt_scan_ctrl_if #(
  parameter int TAGT_LENGTH = bwt_pkg::TAGT_LENGTH,
  parameter int REF_LENGTH  = bwt_pkg::REF_LENGTH
);

  logic [TAGT_LENGTH-1:0] tgt_addr;
  logic [REF_LENGTH-1:0]  ref_addr;
  logic                   rd_en;
  logic                   cmp_eq;

  modport master (output tgt_addr, output ref_addr, output rd_en, input cmp_eq);
  modport slave  (input tgt_addr, input ref_addr, input rd_en, output cmp_eq);

endinterface

// File: rtl/bwt_addr_gen.sv
// Window-start (s) and base-index (j) counters with registered target/reference read addresses.
module bwt_addr_gen #(
  parameter int TAGT_NUM    = 64,
  parameter int TAGT_LENGTH = 6,
  parameter int REF_NUM     = 1024,
  parameter int REF_LENGTH  = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   issue_i,
  input  logic                   next_win_i,
  output logic [REF_LENGTH-1:0]  s_o,
  output logic [TAGT_LENGTH-1:0] tgt_addr_o,
  output logic [REF_LENGTH-1:0]  ref_addr_o,
  output logic                   rd_en_o,
  output logic                   last_win_o,
  output logic                   last_base_o
);

  localparam logic [REF_LENGTH-1:0]  LAST_S = REF_LENGTH'(REF_NUM - TAGT_NUM);
  localparam logic [REF_LENGTH-1:0]  S_ONE  = REF_LENGTH'(1);
  localparam logic [TAGT_LENGTH:0]   J_END  = (TAGT_LENGTH+1)'(TAGT_NUM);
  localparam logic [TAGT_LENGTH:0]   J_ONE  = (TAGT_LENGTH+1)'(1);

  logic [REF_LENGTH-1:0]  s_q, s_d;
  logic [TAGT_LENGTH:0]   j_q, j_d;
  logic [TAGT_LENGTH-1:0] tgt_q, tgt_d;
  logic [REF_LENGTH-1:0]  ref_q, ref_d;
  logic                   rd_en_q, rd_en_d;

  // j counts pairs already issued in this window; a window change issues base 0 of the new window at once.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    s_d     = s_q;
    j_d     = j_q;
    tgt_d   = tgt_q;
    ref_d   = ref_q;
    rd_en_d = 1'b0;
    if (clr_i) begin
      s_d = '0;
      j_d = '0;
    end else if (next_win_i) begin
      s_d     = s_q + S_ONE;
      j_d     = J_ONE;
      tgt_d   = '0;
      ref_d   = s_q + S_ONE;
      rd_en_d = 1'b1;
    end else if (issue_i) begin
      tgt_d   = j_q[TAGT_LENGTH-1:0];
      ref_d   = s_q + REF_LENGTH'(j_q);
      j_d     = j_q + J_ONE;
      rd_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      s_q     <= '0;
      j_q     <= '0;
      tgt_q   <= '0;
      ref_q   <= '0;
      rd_en_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      j_q     <= j_d;
      tgt_q   <= tgt_d;
      ref_q   <= ref_d;
      rd_en_q <= rd_en_d;
    end
  end

  assign s_o         = s_q;
  assign tgt_addr_o  = tgt_q;
  assign ref_addr_o  = ref_q;
  assign rd_en_o     = rd_en_q;
  assign last_win_o  = (s_q == LAST_S);
  assign last_base_o = (j_q == J_END);

endmodule

// File: rtl/bwt_scan_ctrl.sv
// Exact-match scan sequencer: walks every reference window, counts consecutive base matches and reports full-window hits.
module bwt_scan_ctrl #(
  parameter int TAGT_NUM    = bwt_pkg::TAGT_NUM,
  parameter int TAGT_LENGTH = bwt_pkg::TAGT_LENGTH,
  parameter int REF_NUM     = bwt_pkg::REF_NUM,
  parameter int REF_LENGTH  = bwt_pkg::REF_LENGTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  bwt_scan_ctrl_if.master        mem,
  output logic [TAGT_LENGTH:0]   match_run_o,
  output logic                   hit_valid_o,
  output logic [REF_LENGTH-1:0]  hit_pos_o,
  output logic [REF_LENGTH-1:0]  hit_cnt_o,
  output logic                   busy_o,
  output logic                   done_o
);

  import bwt_pkg::*;

  localparam logic [TAGT_LENGTH:0]  RUN_LAST = (TAGT_LENGTH+1)'(TAGT_NUM - 1);
  localparam logic [TAGT_LENGTH:0]  RUN_ONE  = (TAGT_LENGTH+1)'(1);
  localparam logic [REF_LENGTH-1:0] CNT_ONE  = REF_LENGTH'(1);

  scan_state_t            state_q, state_d;
  logic [TAGT_LENGTH:0]   match_run_q, match_run_d;
  logic [REF_LENGTH-1:0]  hit_pos_q, hit_pos_d;
  logic [REF_LENGTH-1:0]  hit_cnt_q, hit_cnt_d;
  logic                   cmp_vld_q, cmp_vld_d;

  logic [REF_LENGTH-1:0]  s;
  logic                   last_win, last_base;
  logic                   clr, issue, next_win;
  logic                   cmp_hit, cmp_miss, full;

  bwt_addr_gen #(
    .TAGT_NUM   (TAGT_NUM),
    .TAGT_LENGTH(TAGT_LENGTH),
    .REF_NUM    (REF_NUM),
    .REF_LENGTH (REF_LENGTH)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr),
    .issue_i    (issue),
    .next_win_i (next_win),
    .s_o        (s),
    .tgt_addr_o (mem.tgt_addr),
    .ref_addr_o (mem.ref_addr),
    .rd_en_o    (mem.rd_en),
    .last_win_o (last_win),
    .last_base_o(last_base)
  );

  // cmp_eq belongs to the pair shown on rd_en one cycle earlier; a mismatch voids the pair in flight.
  assign cmp_hit   = (state_q == SCAN) & cmp_vld_q & mem.cmp_eq;
  assign cmp_miss  = (state_q == SCAN) & cmp_vld_q & ~mem.cmp_eq;
  assign full      = cmp_hit & (match_run_q == RUN_LAST);
  assign cmp_vld_d = mem.rd_en & ~cmp_miss;

  always_comb begin
    state_d     = state_q;
    match_run_d = match_run_q;
    hit_pos_d   = hit_pos_q;
    hit_cnt_d   = hit_cnt_q;
    clr         = 1'b0;
    issue       = 1'b0;
    next_win    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d     = SCAN;
          clr         = 1'b1;
          match_run_d = '0;
          hit_cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cmp_miss) begin
          match_run_d = '0;
          if (last_win) state_d = FIN;
          else          next_win = 1'b1;
        end else if (full) begin
          state_d     = HIT;
          match_run_d = match_run_q + RUN_ONE;
          hit_pos_d   = s;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
        end else begin
          if (cmp_hit) match_run_d = match_run_q + RUN_ONE;
          issue = ~last_base;
        end
      end
      HIT: begin
        match_run_d = '0;
        if (last_win) begin
          state_d = FIN;
        end else begin
          state_d  = SCAN;
          next_win = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      match_run_q <= '0;
      hit_pos_q   <= '0;
      hit_cnt_q   <= '0;
      cmp_vld_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      match_run_q <= match_run_d;
      hit_pos_q   <= hit_pos_d;
      hit_cnt_q   <= hit_cnt_d;
      cmp_vld_q   <= cmp_vld_d;
    end
  end

  assign match_run_o = match_run_q;
  assign hit_valid_o = (state_q == HIT);
  assign hit_pos_o   = hit_pos_q;
  assign hit_cnt_o   = hit_cnt_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == FIN);

endmodule
